// File: rtl/delay_line_if.sv
// Sample-stream bundle for the delay line: strobe, delay/freeze controls,
// input sample in one direction; delayed sample, valid pulse, fill flag back.
interface delay_line_if #(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 15
);
  logic                  EN;
  logic [ADDR_WIDTH-1:0] DELAY;
  logic                  FREEZE;
  logic [DATA_WIDTH-1:0] DI;
  logic [DATA_WIDTH-1:0] DO;
  logic                  DO_VALID;
  logic                  FILLED;

  modport master (
    output EN, DELAY, FREEZE, DI,
    input  DO, DO_VALID, FILLED
  );

  modport slave (
    input  EN, DELAY, FREEZE, DI,
    output DO, DO_VALID, FILLED
  );
endinterface

// File: rtl/delay_line.sv
// Circular-buffer delay line: returns the sample written D strobes earlier,
// with arbitrary (non-power-of-two) wrap, fill masking and freeze/loop mode.
module delay_line #(
  parameter int DATA_WIDTH = 31,
  parameter int ADDR_WIDTH = 15,
  parameter int SIZE       = 20000
) (
  input logic         CLK,
  input logic         RST,
  delay_line_if.slave bus
);
  // RAM index width; pointers never exceed SIZE-1 so the slice is lossless
  localparam int RAW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST   = ADDR_WIDTH'(SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] SIZE_A = ADDR_WIDTH'(SIZE);
  localparam logic [ADDR_WIDTH:0]   SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

  logic [DATA_WIDTH-1:0] ram [SIZE];
  logic [DATA_WIDTH-1:0] ram_q;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] fill;
  logic [ADDR_WIDTH-1:0] d_eff;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  mask;

  logic                  v1;
  logic                  mask1;
  logic [DATA_WIDTH-1:0] do_r;
  logic                  do_valid_r;
  logic                  filled_r;

  // Effective delay: 0 behaves as 1, anything at or beyond SIZE clamps to SIZE-1
  always_comb begin
    d_eff = bus.DELAY;
    if (bus.DELAY == '0) begin
      d_eff = ADDR_WIDTH'(1);
    end else if ({1'b0, bus.DELAY} >= SIZE_W) begin
      d_eff = LAST;
    end
  end

  // Read address with exact modulo-SIZE wrap; the add of SIZE may overflow
  // ADDR_WIDTH when SIZE == 2**ADDR_WIDTH, which modular arithmetic absorbs
  always_comb begin
    rd_addr = wr_ptr - d_eff;
    if (wr_ptr < d_eff) begin
      rd_addr = rd_addr + SIZE_A;
    end
    mask = (fill < d_eff);
  end

  // Sample RAM: write at wr_ptr unless frozen, registered read at rd_addr;
  // no reset so it maps onto block RAM and keeps contents across RST
  always_ff @(posedge CLK) begin
    if (!RST && bus.EN) begin
      if (!bus.FREEZE) begin
        ram[wr_ptr[RAW-1:0]] <= bus.DI;
      end
      ram_q <= ram[rd_addr[RAW-1:0]];
    end
  end

  // Pointer, fill count, mask/valid pipeline and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      fill       <= '0;
      v1         <= 1'b0;
      mask1      <= 1'b0;
      do_r       <= '0;
      do_valid_r <= 1'b0;
      filled_r   <= 1'b0;
    end else begin
      v1         <= bus.EN;
      do_valid_r <= v1;
      if (v1) begin
        do_r <= mask1 ? '0 : ram_q;
      end
      if (bus.EN) begin
        mask1    <= mask;
        filled_r <= ~mask;
        wr_ptr   <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        if (!bus.FREEZE && fill != LAST) begin
          fill <= fill + 1'b1;
        end
      end
    end
  end

  assign bus.DO       = do_r;
  assign bus.DO_VALID = do_valid_r;
  assign bus.FILLED   = filled_r;
endmodule

// File: tb/tb_delay_line.sv
// Bench for delay_line: two instances (SIZE=20000 and SIZE=10) share one
// stimulus stream; each is checked against its own behavioural model.
module tb_delay_line;
  localparam int DW       = 31;
  localparam int AW       = 15;
  localparam int SZ_BIG   = 20000;
  localparam int SZ_SMALL = 10;
  localparam int KEY_STEP = 32768;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  delay_line_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_big ();
  delay_line_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_small ();

  delay_line #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ_BIG)) dut_big (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_big)
  );

  delay_line #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ_SMALL)) dut_small (
    .CLK (CLK),
    .RST (RST),
    .bus (bus_small)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, index 0 = big instance, 1 = small instance
  int              sizes [2] = '{SZ_BIG, SZ_SMALL};
  int              m_wr [2];
  int              m_fill [2];
  bit              m_filled [2];
  bit              m_dov [2];
  logic [DW-1:0]   m_do [2];
  bit              m_dok [2];
  bit              m_pv [2];
  logic [DW-1:0]   m_pd [2];
  bit              m_pk [2];
  logic [DW-1:0]   mem [int];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // One clock edge of the model: sample with delay D comes out 2 edges after its strobe
  task automatic model_edge(input int i, input bit rst, input bit en, input int delay,
                            input bit frz, input logic [DW-1:0] di);
    int s, d, rd;
    s = sizes[i];
    if (rst) begin
      m_wr[i] = 0; m_fill[i] = 0; m_filled[i] = 1'b0;
      m_do[i] = '0; m_dok[i] = 1'b1; m_dov[i] = 1'b0; m_pv[i] = 1'b0;
    end else begin
      m_dov[i] = m_pv[i];
      if (m_pv[i]) begin
        m_do[i]  = m_pd[i];
        m_dok[i] = m_pk[i];
      end
      m_pv[i] = en;
      if (en) begin
        d  = (delay == 0) ? 1 : ((delay >= s) ? s - 1 : delay);
        rd = (m_wr[i] - d + s) % s;
        if (m_fill[i] < d) begin
          m_pd[i] = '0; m_pk[i] = 1'b1;
        end else if (mem.exists(i * KEY_STEP + rd)) begin
          m_pd[i] = mem[i * KEY_STEP + rd]; m_pk[i] = 1'b1;
        end else begin
          m_pk[i] = 1'b0;
        end
        m_filled[i] = (m_fill[i] >= d);
        if (!frz) begin
          mem[i * KEY_STEP + m_wr[i]] = di;
          if (m_fill[i] < s - 1) m_fill[i]++;
        end
        m_wr[i] = (m_wr[i] + 1) % s;
      end
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input int delay, input bit frz,
                       input logic [DW-1:0] di);
    RST = rst;
    bus_big.EN = en;   bus_big.DELAY = AW'(delay);   bus_big.FREEZE = frz;   bus_big.DI = di;
    bus_small.EN = en; bus_small.DELAY = AW'(delay); bus_small.FREEZE = frz; bus_small.DI = di;
    for (int i = 0; i < 2; i++) model_edge(i, rst, en, delay, frz, di);
    @(posedge CLK);
    @(negedge CLK);
    check("big.DO_VALID", 64'(bus_big.DO_VALID), 64'(m_dov[0]));
    check("big.FILLED", 64'(bus_big.FILLED), 64'(m_filled[0]));
    if (m_dok[0]) check("big.DO", 64'(bus_big.DO), 64'(m_do[0]));
    check("small.DO_VALID", 64'(bus_small.DO_VALID), 64'(m_dov[1]));
    check("small.FILLED", 64'(bus_small.FILLED), 64'(m_filled[1]));
    if (m_dok[1]) check("small.DO", 64'(bus_small.DO), 64'(m_do[1]));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_dok[i] = 1'b0; m_pv[i] = 1'b0; m_pk[i] = 1'b0;
      m_wr[i] = 0; m_fill[i] = 0; m_filled[i] = 1'b0; m_dov[i] = 1'b0; m_do[i] = '0;
    end

    // Reset state
    repeat (2) cycle(1'b1, 1'b0, 0, 1'b0, '0);

    // DELAY=4, strobe every 4th cycle, DI=1,2,3,...
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 1'b1, 4, 1'b0, DW'(k));
      repeat (3) cycle(1'b0, 1'b0, 4, 1'b0, '0);
    end

    // DELAY=3, 25 samples, crossing pointer and read wrap on the small buffer
    cycle(1'b1, 1'b0, 0, 1'b0, '0);
    for (int k = 1; k <= 25; k++) begin
      cycle(1'b0, 1'b1, 3, 1'b0, DW'(k));
      cycle(1'b0, 1'b0, 3, 1'b0, '0);
    end

    // Clamp: DELAY=0 and DELAY=1, then DELAY=12 and DELAY=9 after fresh resets
    for (int p = 0; p < 4; p++) begin
      cycle(1'b1, 1'b0, 0, 1'b0, '0);
      for (int k = 1; k <= 14; k++) begin
        cycle(1'b0, 1'b1, (p == 0) ? 0 : (p == 1) ? 1 : (p == 2) ? 12 : 9, 1'b0, DW'(k + 50));
      end
      repeat (2) cycle(1'b0, 1'b0, 1, 1'b0, '0);
    end

    // Back-to-back strobes, DELAY=1, DI=100..110
    cycle(1'b1, 1'b0, 0, 1'b0, '0);
    for (int k = 100; k <= 110; k++) cycle(1'b0, 1'b1, 1, 1'b0, DW'(k));
    repeat (3) cycle(1'b0, 1'b0, 1, 1'b0, '0);

    // Fill 10 samples, then freeze with DI=0xFF and DELAY=5 for 20 strobes
    cycle(1'b1, 1'b0, 0, 1'b0, '0);
    for (int k = 1; k <= 10; k++) cycle(1'b0, 1'b1, 5, 1'b0, DW'(k));
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, 5, 1'b1, DW'(8'hFF));
    repeat (3) cycle(1'b0, 1'b0, 5, 1'b0, '0);

    // Mid-stream reset one cycle after a strobe, DELAY=2
    for (int k = 1; k <= 6; k++) cycle(1'b0, 1'b1, 2, 1'b0, DW'(k + 200));
    cycle(1'b1, 1'b0, 2, 1'b0, '0);
    for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b1, 2, 1'b0, DW'(k + 300));
    repeat (3) cycle(1'b0, 1'b0, 2, 1'b0, '0);

    // Reset coinciding with a strobe: reset wins
    cycle(1'b0, 1'b1, 2, 1'b0, DW'(400));
    cycle(1'b1, 1'b1, 2, 1'b0, DW'(401));
    repeat (3) cycle(1'b0, 1'b1, 1, 1'b0, DW'(402));

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      bit r, e, f;
      int d;
      r = ($urandom_range(0, 63) == 0);
      e = ($urandom_range(0, 9) < 6);
      f = ($urandom_range(0, 7) == 0);
      d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 32767)) : int'($urandom_range(0, 12));
      cycle(r, e, d, f, DW'($urandom));
    end
    repeat (3) cycle(1'b0, 1'b0, 1, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/delay_line.md
# delay_line

Parametrised circular-buffer delay line for the audio effects chain (echo, chorus, looper). It holds up to SIZE-1 samples of history in an internal dual-port RAM and manages its own write/read pointers with arbitrary (non-power-of-two) wrap. It returns the sample written DELAY strobes earlier, with a registered output and a valid pulse. It adds fill tracking, which suppresses stale RAM contents after reset, and a freeze/loop mode.

## Interface
- DATA_WIDTH, 31, sample width in bits
- ADDR_WIDTH, 15, pointer/delay width; must satisfy 2^ADDR_WIDTH >= SIZE
- SIZE, 20000, buffer depth in samples (any value >= 2)
- CLK  input  1  system clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- EN  input  1  sample strobe; one sample written/read per cycle with EN=1
- DELAY  input  ADDR_WIDTH  requested delay in samples, sampled on each EN cycle
- FREEZE  input  1  1 = suppress RAM writes (loop playback), sampled on each EN cycle
- DI  input  DATA_WIDTH  input sample, sampled on EN cycle
- DO  output  DATA_WIDTH  delayed sample, registered
- DO_VALID  output  1  one-cycle pulse marking a new DO
- FILLED  output  1  1 when the fill count >= effective delay of the last EN

## Operation
- State: wr_ptr (0..SIZE-1), fill (0..SIZE-1, saturating), 2-stage valid/mask pipeline, RAM array [SIZE].
- Effective delay D:
  - DELAY=0 → 1.
  - DELAY>=SIZE → SIZE-1.
  - Otherwise D=DELAY.
- Read address on EN cycle:
  - rd = wr_ptr-D if wr_ptr>=D.
  - rd = wr_ptr+SIZE-D otherwise.
  - rd never equals wr_ptr, so no read-during-write hazard.
- On EN with FREEZE=0:
  - RAM[wr_ptr] <= DI.
  - fill <= min(fill+1, SIZE-1).
- On EN with FREEZE=1:
  - No write; fill is unchanged.
  - Buffer replays with period SIZE samples.
- On every EN:
  - RAM read at rd (registered RAM output).
  - wr_ptr <= (wr_ptr==SIZE-1) ? 0 : wr_ptr+1.
  - mask flag = (fill < D), evaluated with pre-update fill.
- Output stage: DO <= mask ? 0 : RAM_q. DO_VALID <= delayed EN.
- FILLED is registered, updated on each EN, and reset to 0.
- DELAY changes take effect on the next EN; there is no interpolation or glitch smoothing.
- RAM contents are not cleared by RST; the fill-mask guarantees zeros until D genuine samples exist.

## Timing
- Reset values: DO=0, DO_VALID=0, FILLED=0, wr_ptr=0, fill=0, pipeline valid bits=0.
- Latency: EN at edge t → RAM read at edge t → DO/DO_VALID updated at edge t+1. DO_VALID is high in the cycle following edge t+1, i.e. 2 cycles after EN is presented.
- Throughput: EN may be high every cycle; each EN yields exactly one DO_VALID pulse, in order.
- DO holds its value between pulses.
- RST has priority over EN in the same cycle: no write, no pointer advance.
- RST clears in-flight samples; no DO_VALID is produced for an EN in the 2 cycles before RST.
- Wrap: after writing at address SIZE-1, wr_ptr returns to 0 on the same edge.
- Read-address wrap is exact for all D in 1..SIZE-1.
- fill saturation at SIZE-1 is permanent until RST.

## Test plan
- Reset, SIZE=20000, DELAY=4, DI=1,2,3,… on EN every 4th cycle:
  - First 4 DO = 0 with DO_VALID, then DO = 1,2,3,…
  - Each DO_VALID arrives exactly 2 cycles after its EN.
  - FILLED rises with the 5th sample.
- SIZE=10 override, DELAY=3, 25 samples DI=k:
  - Output k-3 for k>=4, correct across wr_ptr wrap 9→0 and read wrap.
- Clamp checks, SIZE=10:
  - DELAY=0 gives same output as DELAY=1.
  - DELAY=12 gives same output as DELAY=9 (first 9 outputs 0).
- Back-to-back EN every cycle, DELAY=1, DI=100..110:
  - DO_VALID continuous; DO = 0,100,101,… with 2-cycle offset.
- SIZE=10, write 10 samples DI=1..10, then FREEZE=1 with DI=0xFF, DELAY=5, 20 more EN:
  - Outputs cycle 6,7,8,9,10,1,2,3,4,5 repeatedly; 0xFF never appears.
- Mid-stream RST one cycle after EN, DELAY=2:
  - No DO_VALID for that EN; DO=0, FILLED=0.
  - Next 2 outputs are 0 even though RAM still holds old data.
